// File: rtl/cal_div_unit.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// IDLE/EXEC/DONE control matching the shift-add multiplier next to it.
module cal_div_unit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_start,
  input  logic             op_clear,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             op_done,
  output logic             div_by_zero,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] divisor_q;

  // The shifted partial remainder carries one extra bit so divisors above
  // 2^(WIDTH-1) still produce a correct result.
  logic [WIDTH:0]   r_ext;
  logic [WIDTH-1:0] diff;
  logic             trial_ok;

  assign r_ext    = {remainder, quotient[WIDTH-1]};
  assign trial_ok = (r_ext >= {1'b0, divisor_q});
  assign diff     = r_ext[WIDTH-1:0] - divisor_q;
  assign state    = st;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= IDLE;
      count       <= '0;
      divisor_q   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      op_done     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (!op_clear && op_start) begin
            divisor_q <= divisor;
            count     <= '0;
            if (divisor == '0) begin
              st          <= DONE;
              quotient    <= '1;
              remainder   <= dividend;
              op_done     <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              st          <= EXEC;
              quotient    <= dividend;
              remainder   <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        EXEC: begin
          if (op_clear) begin
            st    <= IDLE;
            count <= '0;
          end else begin
            quotient  <= {quotient[WIDTH-2:0], trial_ok};
            remainder <= trial_ok ? diff : r_ext[WIDTH-1:0];
            count     <= count + 1'b1;
            if (count == CNT_W'(WIDTH - 1)) begin
              st      <= DONE;
              op_done <= 1'b1;
            end
          end
        end
        DONE: begin
          if (op_clear) begin
            st          <= IDLE;
            op_done     <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          st    <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cal_div_unit.sv
// Directed bench for cal_div_unit: table of division vectors plus
// hand-written abort, reset, held-start and clear/start sequences.
module tb_cal_div_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         op_start = 1'b0;
  logic         op_clear = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         op_done;
  logic         div_by_zero;
  logic [1:0]   state;

  int total = 0;
  int bad = 0;

  cal_div_unit #(.WIDTH(W), .CNT_W(7)) dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .op_done(op_done), .div_by_zero(div_by_zero),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dz;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start a division at the next edge (E0) and count edges until op_done.
  task automatic run(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                     input bit hold_start, output int lat, output logic [1:0] st0);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    op_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st0 = state;
    if (!hold_start) op_start = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    lat = 0;
    while (!op_done && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_clear = 1'b0;
  endtask

  initial begin
    int lat;
    logic [1:0] st0;
    bit seen_done;

    vecs[0] = '{64'd1555, 64'd131, 64'd11, 64'd114, 1'b0};
    vecs[1] = '{64'd100, 64'd120, 64'd0, 64'd100, 1'b0};
    vecs[2] = '{64'd1210, 64'd115, 64'd10, 64'd60, 1'b0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
                64'h8000_0000_0000_0000, 1'b0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1,
                64'h7FFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[6] = '{64'h0123_4567_89AB_CDEF, 64'h10, 64'h0012_3456_789A_BCDE, 64'hF, 1'b0};
    vecs[7] = '{64'd1555, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1555, 1'b1};

    #12;
    chk("reset_state", state, 2'b00);
    chk("reset_quotient", quotient, '0);
    chk("reset_remainder", remainder, '0);
    chk("reset_done", op_done, 1'b0);
    chk("reset_dz", div_by_zero, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run(vecs[i].dvd, vecs[i].dvs, 1'b0, lat, st0);
      chk($sformatf("v%0d_state_after_e0", i), st0, vecs[i].exp_dz ? 2'b10 : 2'b01);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_dz ? 0 : 64);
      chk($sformatf("v%0d_quotient", i), quotient, vecs[i].exp_q);
      chk($sformatf("v%0d_remainder", i), remainder, vecs[i].exp_r);
      chk($sformatf("v%0d_dz", i), div_by_zero, vecs[i].exp_dz);
      chk($sformatf("v%0d_done_state", i), state, 2'b10);
      do_clear();
      chk($sformatf("v%0d_clear_state", i), state, 2'b00);
      chk($sformatf("v%0d_clear_done", i), op_done, 1'b0);
      chk($sformatf("v%0d_clear_dz", i), div_by_zero, 1'b0);
      chk($sformatf("v%0d_q_hold", i), quotient, vecs[i].exp_q);
    end

    // Abort at count=30: IDLE on the next edge, op_done never rises.
    @(negedge clk);
    dividend = 64'd1555;
    divisor  = 64'd131;
    op_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_state", state, 2'b01);
    op_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_clear = 1'b0;
    chk("abort_state", state, 2'b00);
    seen_done = 1'b0;
    repeat (80) begin
      @(negedge clk);
      seen_done |= op_done;
    end
    chk("abort_no_done", seen_done, 1'b0);
    chk("abort_stays_idle", state, 2'b00);

    // Reset mid-EXEC takes effect without a clock edge.
    @(negedge clk);
    dividend = 64'd1555;
    divisor  = 64'd131;
    op_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_state", state, 2'b00);
    chk("rst_mid_quotient", quotient, '0);
    chk("rst_mid_remainder", remainder, '0);
    chk("rst_mid_done", op_done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    run(64'd1555, 64'd131, 1'b0, lat, st0);
    chk("post_rst_latency", lat, 64);
    chk("post_rst_quotient", quotient, 64'd11);
    chk("post_rst_remainder", remainder, 64'd114);
    do_clear();

    // op_start held high through EXEC and DONE does not restart.
    run(64'd1555, 64'd131, 1'b1, lat, st0);
    chk("hold_latency", lat, 64);
    chk("hold_quotient", quotient, 64'd11);
    chk("hold_remainder", remainder, 64'd114);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("hold_done_state", state, 2'b10);
    chk("hold_done_flag", op_done, 1'b1);
    chk("hold_quotient_later", quotient, 64'd11);
    op_start = 1'b0;
    do_clear();
    chk("hold_clear_state", state, 2'b00);

    // op_clear wins over op_start in IDLE.
    @(negedge clk);
    dividend = 64'd1210;
    divisor  = 64'd115;
    op_start = 1'b1;
    op_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_start = 1'b0;
    op_clear = 1'b0;
    chk("clear_wins_state", state, 2'b00);
    chk("clear_wins_quotient", quotient, 64'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
